// File: rtl/shift_operand_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_operand_decoder: decodes an ARM operand2 field, fetches Rm/Rs from the
// register file and presents the barrel-shifter inputs under valid/ready.
// Revision: 1.0
// ---------------------------------------------------------------------------
module shift_operand_decoder #(
  parameter int RF_ADDR_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 imm_flag,
  input  logic [11:0]          op2,
  input  logic                 carry_in,
  output logic                 rf_rd_en,
  output logic [RF_ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0]    rf_data,
  output logic [2:0]           SHFT_OP,
  output logic [DATA_W-1:0]    Shift_Data,
  output logic [7:0]           Shift_Num,
  output logic                 Carry_flag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_illegal
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RM = 3'd1,
    CAP_RM   = 3'd2,
    CAP_RS   = 3'd3,
    OUT      = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b110;

  state_t      state;
  state_t      next_state;
  logic [11:0] op2_q;
  logic        illegal;
  logic [4:0]  imm_amt;

  // Register-specified shifts cannot use bit 7 or the PC as Rm/Rs.
  assign illegal = op2[4] & (op2[7] | (op2[3:0] == 4'hF) | (op2[11:8] == 4'hF));
  assign imm_amt = op2_q[11:7];

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == OUT);
  assign err_illegal = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    rf_rd_en   = 1'b0;
    rf_addr    = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (imm_flag)     next_state = OUT;
          else if (illegal) next_state = ERR;
          else              next_state = ISSUE_RM;
        end
      end
      ISSUE_RM: begin
        rf_rd_en   = 1'b1;
        rf_addr    = RF_ADDR_W'(op2_q[3:0]);
        next_state = CAP_RM;
      end
      CAP_RM: begin
        if (op2_q[4]) begin
          rf_rd_en   = 1'b1;
          rf_addr    = RF_ADDR_W'(op2_q[11:8]);
          next_state = CAP_RS;
        end else begin
          next_state = OUT;
        end
      end
      CAP_RS:  next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op2_q      <= '0;
      SHFT_OP    <= OP_LSL;
      Shift_Data <= '0;
      Shift_Num  <= '0;
      Carry_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op2_q      <= op2;
            Carry_flag <= carry_in;
            if (imm_flag) begin
              // Rotated immediate: 8-bit value rotated right by twice the field.
              SHFT_OP    <= OP_ROR;
              Shift_Data <= DATA_W'(op2[7:0]);
              Shift_Num  <= {3'b000, op2[11:8], 1'b0};
            end
          end
        end
        CAP_RM: begin
          Shift_Data <= rf_data;
          if (op2_q[4]) begin
            SHFT_OP <= {1'b0, op2_q[6:5]};
          end else begin
            case (op2_q[6:5])
              2'b00: begin
                SHFT_OP   <= OP_LSL;
                Shift_Num <= {3'b000, imm_amt};
              end
              2'b01: begin
                SHFT_OP   <= OP_LSR;
                Shift_Num <= (imm_amt == 5'd0) ? 8'd32 : {3'b000, imm_amt};
              end
              2'b10: begin
                SHFT_OP   <= OP_ASR;
                Shift_Num <= (imm_amt == 5'd0) ? 8'd32 : {3'b000, imm_amt};
              end
              default: begin
                // ROR #0 encodes RRX: a one-bit rotate through carry.
                SHFT_OP   <= (imm_amt == 5'd0) ? OP_RRX : OP_ROR;
                Shift_Num <= (imm_amt == 5'd0) ? 8'd1 : {3'b000, imm_amt};
              end
            endcase
          end
        end
        CAP_RS:  Shift_Num <= rf_data[7:0];
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_operand_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_shift_operand_decoder: directed vector table plus hand-written sequences
// for backpressure, illegal encodings and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_shift_operand_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, imm_flag, carry_in;
  logic [11:0] op2;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  SHFT_OP;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic        Carry_flag, out_valid, out_ready, err_illegal;

  shift_operand_decoder #(.RF_ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_flag(imm_flag), .op2(op2), .carry_in(carry_in),
    .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .SHFT_OP(SHFT_OP), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num),
    .Carry_flag(Carry_flag), .out_valid(out_valid), .out_ready(out_ready),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Synchronous register-file model: data appears the cycle after the strobe.
  logic [31:0] mem [16];
  always @(posedge clk) if (rf_rd_en) rf_data <= mem[rf_addr];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        imm;
    logic [11:0] op2;
    logic        cin;
    logic [31:0] rm_val;
    logic [31:0] rs_val;
    logic [2:0]  e_op;
    logic [31:0] e_data;
    logic [7:0]  e_num;
    int          e_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int c;
    logic seen;
    vec_t v;

    vecs[0]  = '{1'b1, 12'h4FF, 1'b0, 32'h0,        32'h0,   3'b011, 32'h000000FF, 8'h08, 1};
    vecs[1]  = '{1'b1, 12'hF12, 1'b1, 32'h0,        32'h0,   3'b011, 32'h00000012, 8'h1E, 1};
    vecs[2]  = '{1'b0, 12'h023, 1'b0, 32'hAAAAFF00, 32'h0,   3'b001, 32'hAAAAFF00, 8'h20, 3};
    vecs[3]  = '{1'b0, 12'h062, 1'b1, 32'h12345678, 32'h0,   3'b110, 32'h12345678, 8'h01, 3};
    vecs[4]  = '{1'b0, 12'h062, 1'b0, 32'h12345678, 32'h0,   3'b110, 32'h12345678, 8'h01, 3};
    vecs[5]  = '{1'b0, 12'h004, 1'b0, 32'hDEADBEEF, 32'h0,   3'b000, 32'hDEADBEEF, 8'h00, 3};
    vecs[6]  = '{1'b0, 12'h286, 1'b1, 32'h00000F0F, 32'h0,   3'b000, 32'h00000F0F, 8'h05, 3};
    vecs[7]  = '{1'b0, 12'h047, 1'b0, 32'h80000000, 32'h0,   3'b010, 32'h80000000, 8'h20, 3};
    vecs[8]  = '{1'b0, 12'h268, 1'b0, 32'h0000F00F, 32'h0,   3'b011, 32'h0000F00F, 8'h04, 3};
    vecs[9]  = '{1'b0, 12'h551, 1'b0, 32'hAAAAFF00, 32'h140, 3'b010, 32'hAAAAFF00, 8'h40, 4};
    vecs[10] = '{1'b0, 12'h219, 1'b1, 32'h11111111, 32'h1FF, 3'b000, 32'h11111111, 8'hFF, 4};
    vecs[11] = '{1'b0, 12'h370, 1'b0, 32'h80000001, 32'h0,   3'b011, 32'h80000001, 8'h00, 4};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rf_data = 32'h0;
    rst_n = 1'b0; in_valid = 1'b0; imm_flag = 1'b0; op2 = 12'h0;
    carry_in = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset rf_rd_en", {31'b0, rf_rd_en}, 32'd0);
    chk("reset err", {31'b0, err_illegal}, 32'd0);
    chk("reset Shift_Data", Shift_Data, 32'd0);
    chk("reset Shift_Num/op/carry", {20'b0, Shift_Num, SHFT_OP, Carry_flag}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      mem[v.op2[3:0]] = v.rm_val;
      if (v.e_lat == 4) mem[v.op2[11:8]] = v.rs_val;
      in_valid = 1'b1; imm_flag = v.imm; op2 = v.op2; carry_in = v.cin; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; carry_in = ~v.cin; op2 = 12'h000;
      c = 1;
      while (!out_valid && c < 8) begin
        if (c == 1) begin
          chk($sformatf("v%0d rd1 en", i), {31'b0, rf_rd_en}, 32'd1);
          chk($sformatf("v%0d rd1 addr", i), {28'b0, rf_addr}, {28'b0, v.op2[3:0]});
        end
        if (c == 2) begin
          chk($sformatf("v%0d rd2 en", i), {31'b0, rf_rd_en}, (v.e_lat == 4) ? 32'd1 : 32'd0);
          if (v.e_lat == 4) chk($sformatf("v%0d rd2 addr", i), {28'b0, rf_addr}, {28'b0, v.op2[11:8]});
          chk($sformatf("v%0d busy in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        tick();
        c++;
      end
      chk($sformatf("v%0d latency", i), c, v.e_lat);
      chk($sformatf("v%0d SHFT_OP", i), {29'b0, SHFT_OP}, {29'b0, v.e_op});
      chk($sformatf("v%0d Shift_Data", i), Shift_Data, v.e_data);
      chk($sformatf("v%0d Shift_Num", i), {24'b0, Shift_Num}, {24'b0, v.e_num});
      chk($sformatf("v%0d Carry_flag", i), {31'b0, Carry_flag}, {31'b0, v.cin});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d back to idle", i), {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Backpressure: outputs hold and new requests are ignored while in OUT
    in_valid = 1'b1; imm_flag = 1'b1; op2 = 12'h4FF; carry_in = 1'b1; out_ready = 1'b0;
    tick();
    op2 = 12'h3AB; imm_flag = 1'b1; carry_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      chk($sformatf("bp%0d valid/ready", k), {30'b0, out_valid, in_ready}, 32'd2);
      chk($sformatf("bp%0d data", k), Shift_Data, 32'h000000FF);
      chk($sformatf("bp%0d num/op/c", k), {20'b0, Shift_Num, SHFT_OP, Carry_flag}, {20'b0, 8'h08, 3'b011, 1'b1});
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release idle", {30'b0, in_ready, out_valid}, 32'd2);
    tick();
    chk("bp no stray accept", {30'b0, in_ready, out_valid}, 32'd2);

    // Illegal encodings: bit7 set, Rm=PC, Rs=PC
    for (int k = 0; k < 3; k++) begin
      logic [11:0] bad [3];
      bad[0] = 12'h091; bad[1] = 12'h01F; bad[2] = 12'hF10;
      in_valid = 1'b1; imm_flag = 1'b0; op2 = bad[k]; carry_in = 1'b0;
      tick();
      in_valid = 1'b0;
      chk($sformatf("ill%0d err pulse", k), {30'b0, err_illegal, rf_rd_en}, 32'd2);
      seen = 1'b0;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (err_illegal || rf_rd_en || out_valid) seen = 1'b1;
      end
      chk($sformatf("ill%0d quiet after", k), {31'b0, seen}, 32'd0);
      chk($sformatf("ill%0d idle", k), {31'b0, in_ready}, 32'd1);
    end

    // Reset asserted while in CAP_RS abandons the request
    mem[1] = 32'hAAAAFF00; mem[5] = 32'h00000140;
    in_valid = 1'b1; imm_flag = 1'b0; op2 = 12'h551; carry_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst CAP_RS rd_en low", {31'b0, rf_rd_en}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst async data", Shift_Data, 32'd0);
    chk("rst async num/op/c", {20'b0, Shift_Num, SHFT_OP, Carry_flag}, 32'd0);
    chk("rst async ctrl", {28'b0, out_valid, rf_rd_en, err_illegal, in_ready}, 32'd1);
    #20;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("rst no out_valid", {31'b0, seen}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_operand_decoder.md
Name: shift_operand_decoder

Overview:
- Sequential front end that drives the barrel shifter's operand interface.
- Accepts an ARM data-processing operand2 field, fetches Rm and, for register-specified shifts, Rs through a synchronous register-file read port.
- Decodes the ARM shift encodings (including the #0 special cases) and presents SHFT_OP/Shift_Data/Shift_Num/Carry_flag to the barrel shifter under a valid/ready handshake.

Parameters:
- RF_ADDR_W, 4, register-file address width (R0-R15).
- DATA_W, 32, operand width; fixed at 32 for ARMv7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  decoder can accept a request (high only in IDLE).
- imm_flag  input  1  instruction bit 25 (I).
- op2  input  12  instruction bits [11:0].
- carry_in  input  1  CPSR C flag at issue.
- rf_rd_en  output  1  register-file read strobe.
- rf_addr  output  4  register-file read address.
- rf_data  input  32  read data, valid the cycle after rf_rd_en.
- SHFT_OP  output  3  shift operation to the barrel shifter.
- Shift_Data  output  32  value to shift.
- Shift_Num  output  8  shift amount.
- Carry_flag  output  1  carry into the shifter (RRX).
- out_valid  output  1  shifter inputs valid.
- out_ready  input  1  downstream accepts the shifter inputs.
- err_illegal  output  1  one-cycle pulse when an illegal operand2 is rejected.

Behaviour:
- SHFT_OP encoding: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 110 RRX. This block never emits 100, 101 or 111.
- Reset: async to IDLE. All outputs are 0 except in_ready, which is 1 once in IDLE. A reset asserted mid-operation abandons the request; no out_valid is produced.
- FSM states: IDLE, ISSUE_RM, CAP_RM, CAP_RS, OUT, ERR.
- IDLE, in_valid=1: latch imm_flag, op2 and carry_in.
  - imm_flag=1: Shift_Data={24'b0,op2[7:0]}, Shift_Num={3'b0,op2[11:8],1'b0}, SHFT_OP=011. Go to OUT.
  - Register shift (op2[4]=1) with op2[7]=1, or with Rm==15 or Rs==15: go to ERR. No RF read is issued.
  - Otherwise: go to ISSUE_RM.
- ISSUE_RM: rf_rd_en=1, rf_addr=op2[3:0]. Go to CAP_RM.
- CAP_RM: Shift_Data<=rf_data.
  - Immediate shift (op2[4]=0): amount=op2[11:7], type=op2[6:5]. Go to OUT.
    - LSL: Shift_Num=amount.
    - LSR or ASR with amount 0: Shift_Num=32. Otherwise Shift_Num=amount.
    - ROR with amount 0: SHFT_OP=110 (RRX), Shift_Num=1. Otherwise ROR with Shift_Num=amount.
  - Register shift: SHFT_OP=type. Same cycle: rf_rd_en=1, rf_addr=op2[11:8]. Go to CAP_RS.
- CAP_RS: Shift_Num<=rf_data[7:0], unmodified. Values of 0 and of 32 or more pass through to the shifter. Go to OUT.
- OUT: out_valid=1. SHFT_OP, Shift_Data, Shift_Num and Carry_flag are held stable until out_ready=1, then go to IDLE.
- ERR: err_illegal=1 for exactly one cycle, then go to IDLE.
- Carry_flag equals the latched carry_in for every operation.
- Latency from the accept cycle to the first out_valid cycle:
  - Immediate operand: 1 cycle.
  - Immediate shift: 3 cycles.
  - Register shift: 4 cycles.
- Throughput: no overlap. in_valid is ignored outside IDLE.
- rf_rd_en is low in IDLE, CAP_RS, OUT and ERR.

Test Plan:
1. Immediate operand: imm_flag=1, op2=12'h4FF. Required: out_valid 1 cycle after accept with Shift_Data=32'h000000FF, Shift_Num=8'h08, SHFT_OP=011.
2. LSR #0: imm_flag=0, op2=12'h023, R3=32'hAAAAFF00. Required: rf_rd_en with rf_addr=3 one cycle after accept; out_valid 3 cycles after accept with Shift_Data=32'hAAAAFF00, Shift_Num=8'h20, SHFT_OP=001.
3. ROR #0 (RRX): op2=12'h062, carry_in=1. Required: SHFT_OP=110, Shift_Num=8'h01, Carry_flag=1. Repeat with carry_in=0; Carry_flag=0.
4. Register ASR: op2=12'h551, R1=32'hAAAAFF00, R5=32'h00000140. Required: two RF reads (addr 1, then addr 5) on consecutive cycles; out_valid 4 cycles after accept with Shift_Num=8'h40, SHFT_OP=010.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT while pulsing in_valid. Required: outputs stable, in_ready=0, request not accepted; IDLE in the cycle after out_ready=1.
6. Illegal and reset: op2=12'h091 gives one err_illegal pulse, no rf_rd_en and no out_valid. Separately, assert rst_n=0 during CAP_RS; all outputs go to 0 immediately and no out_valid follows.
